// File: rtl/vga_pkg.sv
// Shared constants for the 8x8 monochrome VGA display path: opcodes, geometry, FSM encoding.
package vga_pkg;
    localparam int FB_W    = 8;
    localparam int FB_H    = 8;
    localparam int FB_BITS = FB_W * FB_H;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_SET       = 3'd1;
    localparam logic [2:0] OP_CLR       = 3'd2;
    localparam logic [2:0] OP_TOGGLE    = 3'd3;
    localparam logic [2:0] OP_WRITE_ROW = 3'd4;
    localparam logic [2:0] OP_CLEAR_ALL = 3'd5;
    localparam logic [2:0] OP_SWAP      = 3'd6;
    localparam logic [2:0] OP_SCROLL    = 3'd7;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_CLEAR      = 2'd1;
    localparam state_t ST_WAIT_VSYNC = 2'd2;
endpackage

// File: rtl/vga_vsync_edge_detect.sv
// Synchronises the active-low vsync input and pulses for one cycle on the start of vertical sync.
module vga_vsync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic vsync_in,
    output logic fall_pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Flops reset high so a low vsync coming out of reset is not seen as an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], vsync_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign fall_pulse = prev & ~sync[SYNC_STAGES-1];
endmodule

// File: rtl/vga_framebuffer_writer.sv
// Command-driven 8x8 back buffer with vsync-aligned copy to the front buffer.
// Optional SCROLL opcode enabled by defining VGA_FRAMEBUFFER_WRITER_SCROLL_EN.
//
// state      | meaning
// IDLE       | accepting commands; pixel/row edits complete at acceptance
// CLEAR      | zeroing one back-buffer row per cycle, rows 0..7
// WAIT_VSYNC | holding until the next vsync falling edge, then front <= back
module vga_framebuffer_writer
    import vga_pkg::*;
#(
    parameter int VSYNC_SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [2:0]         cmd_x,
    input  logic [2:0]         cmd_y,
    input  logic [7:0]         cmd_data,
    input  logic               vga_vsync,
    output logic [FB_BITS-1:0] framebuffer,
    output logic               busy,
    output logic               frame_swapped
);
    state_t             state;
    logic [2:0]         row_cnt;
    logic [FB_BITS-1:0] back;
    logic [FB_BITS-1:0] front;
    logic               vsync_fall;

    vga_vsync_edge_detect #(
        .SYNC_STAGES(VSYNC_SYNC_STAGES)
    ) u_vsync_edge (
        .clock      (clock),
        .reset      (reset),
        .vsync_in   (vga_vsync),
        .fall_pulse (vsync_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            row_cnt       <= 3'd0;
            back          <= '0;
            front         <= '0;
            frame_swapped <= 1'b0;
        end else begin
            frame_swapped <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_SET:       back[{cmd_y, cmd_x}] <= 1'b1;
                            OP_CLR:       back[{cmd_y, cmd_x}] <= 1'b0;
                            OP_TOGGLE:    back[{cmd_y, cmd_x}] <= ~back[{cmd_y, cmd_x}];
                            OP_WRITE_ROW: back[{cmd_y, 3'b000} +: FB_W] <= cmd_data;
                            OP_CLEAR_ALL: begin
                                state   <= ST_CLEAR;
                                row_cnt <= 3'd0;
                            end
                            OP_SWAP:      state <= ST_WAIT_VSYNC;
`ifdef VGA_FRAMEBUFFER_WRITER_SCROLL_EN
                            // Row 0 sits in the low byte, so scrolling up shifts the vector right.
                            OP_SCROLL: begin
                                if (cmd_x[0])
                                    back <= {back[FB_BITS-FB_W-1:0], cmd_data};
                                else
                                    back <= {cmd_data, back[FB_BITS-1:FB_W]};
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    back[{row_cnt, 3'b000} +: FB_W] <= '0;
                    row_cnt <= row_cnt + 3'd1;
                    if (row_cnt == 3'd7)
                        state <= ST_IDLE;
                end
                ST_WAIT_VSYNC: begin
                    if (vsync_fall) begin
                        front         <= back;
                        frame_swapped <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign framebuffer = front;
endmodule
